// File: rtl/phy_rx_lane_deser_pkg.sv
// Shared definitions for the PHY RX lane deserialiser:
// default comma symbol and per-lane alignment state encodings.
package phy_rx_lane_deser_pkg;

    localparam logic [7:0] COMMA_DEF = 8'hBC;
    localparam int MAX_COMMAS = 15;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        ACTIVE   = 2'd2
    } lane_state_t;

endpackage

// File: rtl/phy_rx_lane_deser_if.sv
// Lane bundle between the serial front end and the RX deserialiser:
// serial bits and enables in, symbols and lane status out.
interface phy_rx_lane_deser_if #(
    parameter int LANES = 2,
    parameter int W     = 8
);
    logic [LANES-1:0]   serial_in;
    logic [LANES-1:0]   lane_enable;
    logic [LANES*W-1:0] data_out;
    logic [LANES-1:0]   valid_out;
    logic [LANES-1:0]   sym_strobe;
    logic [LANES-1:0]   active;
    logic               all_active;

    modport master (
        output serial_in, lane_enable,
        input  data_out, valid_out, sym_strobe, active, all_active
    );

    modport slave (
        input  serial_in, lane_enable,
        output data_out, valid_out, sym_strobe, active, all_active
    );
endinterface

// File: rtl/phy_rx_lane_align.sv
// Single-lane symbol aligner: sliding comma hunt, comma-count lock,
// then fixed-phase symbol capture until reset or disable.
module phy_rx_lane_align
    import phy_rx_lane_deser_pkg::*;
#(
    parameter int         W             = 8,
    parameter logic [W-1:0] COMMA       = W'(COMMA_DEF),
    parameter int         ACTIVE_COMMAS = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         serial,
    output logic [W-1:0] data,
    output logic         valid,
    output logic         strobe,
    output logic         active
);

    localparam int CW = $clog2(W);

    lane_state_t   state_q, state_d;
    logic [W-2:0]  sr;
    logic [W-1:0]  nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    cc_q, cc_d;
    logic [W-1:0]  data_d;
    logic          valid_d;
    logic          strobe_d;
    logic          boundary;
    logic          is_comma;

    assign nxt      = {sr, serial};
    assign boundary = (cnt_q == CW'(W - 1));
    assign is_comma = (nxt == COMMA);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cc_d     = cc_q;
        data_d   = data;
        valid_d  = 1'b0;
        strobe_d = 1'b0;
        if (!enable) begin
            state_d = UNLOCKED;
            cnt_d   = '0;
            cc_d    = '0;
        end else begin
            unique case (1'b1)
                (state_q == UNLOCKED): begin
                    if (is_comma) begin
                        cnt_d    = '0;
                        cc_d     = 4'd1;
                        strobe_d = 1'b1;
                        state_d  = (ACTIVE_COMMAS == 1) ? ACTIVE : LOCKING;
                    end
                end
                (state_q == LOCKING): begin
                    if (boundary) begin
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                        if (is_comma) begin
                            cc_d = cc_q + 4'd1;
                            if (cc_d == 4'(ACTIVE_COMMAS)) state_d = ACTIVE;
                        end else begin
                            cc_d    = '0;
                            state_d = UNLOCKED;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                (state_q == ACTIVE): begin
                    if (boundary) begin
                        cnt_d    = '0;
                        strobe_d = 1'b1;
                        // idle commas keep the last data symbol visible
                        if (!is_comma) begin
                            data_d  = nxt;
                            valid_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    cnt_d   = '0;
                    cc_d    = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNLOCKED;
            sr      <= '0;
            cnt_q   <= '0;
            cc_q    <= '0;
            data    <= '0;
            valid   <= 1'b0;
            strobe  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr      <= nxt[W-2:0];
            cnt_q   <= cnt_d;
            cc_q    <= cc_d;
            data    <= data_d;
            valid   <= valid_d;
            strobe  <= strobe_d;
        end
    end

    assign active = (state_q == ACTIVE);

endmodule

// File: rtl/phy_rx_lane_deser.sv
// N-lane PHY RX deserialiser: one aligner per lane plus the
// masked all-lanes-active flag for the TX recirculation logic.
module phy_rx_lane_deser
    import phy_rx_lane_deser_pkg::*;
#(
    parameter int           LANES         = 2,
    parameter int           W             = 8,
    parameter logic [W-1:0] COMMA         = W'(COMMA_DEF),
    parameter int           ACTIVE_COMMAS = 4
) (
    input  logic                   clk_32f,
    input  logic                   reset,
    phy_rx_lane_deser_if.slave     rx
);

    logic [LANES*W-1:0] data_v;
    logic [LANES-1:0]   valid_v;
    logic [LANES-1:0]   strobe_v;
    logic [LANES-1:0]   active_v;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        phy_rx_lane_align #(
            .W             (W),
            .COMMA         (COMMA),
            .ACTIVE_COMMAS (ACTIVE_COMMAS)
        ) u_align (
            .clk    (clk_32f),
            .reset  (reset),
            .enable (rx.lane_enable[i]),
            .serial (rx.serial_in[i]),
            .data   (data_v[i*W +: W]),
            .valid  (valid_v[i]),
            .strobe (strobe_v[i]),
            .active (active_v[i])
        );
    end

    assign rx.data_out   = data_v;
    assign rx.valid_out  = valid_v;
    assign rx.sym_strobe = strobe_v;
    assign rx.active     = active_v;
    // disabled lanes are masked; no enabled lane means not active
    assign rx.all_active = (|rx.lane_enable)
                         & (&(active_v | ~rx.lane_enable));

endmodule
